vga_sync_receiver: RTL

- Receiving end of the VGA timing interface: consumes h_sync/v_sync/RGB as produced by the display controller and recovers row/column coordinates plus a pixel-valid qualifier.
- Measures line length (pixel clocks) and frame length (lines), and declares lock after a programmable number of stable frames.
- Used as an on-chip loopback monitor for the controller and as the capture front end for an external VGA source.
- Runs on the 25 MHz pixel clock.

---
 rtl/vga_sync_receiver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: synchronises h/v sync and colour, recovers row/column,
// measures line and frame length, and tracks lock over consecutive good frames.
module vga_sync_receiver #(
  parameter int unsigned H_START     = 144,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_START     = 12,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [2:0] iRGB,
  output logic [8:0] row,
  output logic [9:0] column,
  output logic       pixel_valid,
  output logic [2:0] oRGB,
  output logic       locked,
  output logic       frame_start,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       timing_error
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [9:0] CNT_MAX  = '1;
  localparam logic [9:0] H_LO     = 10'(H_START);
  localparam logic [9:0] H_HI     = 10'(H_START + H_ACTIVE - 1);
  localparam logic [9:0] V_LO     = 10'(V_START);
  localparam logic [9:0] V_HI     = 10'(V_START + V_ACTIVE - 1);
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_FRAMES);

  logic [1:0] hs_q, vs_q;
  logic       hs_hist_q, vs_hist_q;
  logic [2:0] rgb_s1_q, rgb_s2_q;
  logic       h_edge, v_edge;

  logic [9:0] h_count_q, h_count_d, v_count_q, v_count_d;
  logic [9:0] h_total_q, v_total_q, ref_line_q;
  logic [9:0] line_len, frame_len;
  logic [3:0] stable_cnt_q, stable_inc;
  logic       frame_ok_q, first_frame_q, ref_valid_q;
  logic       locked_q, terr_q, fstart_q;
  logic [2:0] orgb_q;
  logic       line_meas, line_ok, frame_good, timeout, lock_err;
  logic       win_now, win_next;
  state_t     state_q;

  function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
    return (h >= H_LO) && (h <= H_HI) && (v >= V_LO) && (v <= V_HI);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_q      <= '0;
      vs_q      <= '0;
      hs_hist_q <= 1'b0;
      vs_hist_q <= 1'b0;
      rgb_s1_q  <= '0;
      rgb_s2_q  <= '0;
    end else begin
      hs_q      <= {hs_q[0], h_sync};
      vs_q      <= {vs_q[0], v_sync};
      hs_hist_q <= hs_q[1];
      vs_hist_q <= vs_q[1];
      rgb_s1_q  <= iRGB;
      rgb_s2_q  <= rgb_s1_q;
    end
  end

  assign h_edge = hs_hist_q & ~hs_q[1];
  assign v_edge = vs_hist_q & ~vs_q[1];

  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (h_edge)
      h_count_d = '0;
    else if (h_count_q != CNT_MAX)
      h_count_d = h_count_q + 10'd1;
    if (v_edge)
      v_count_d = '0;
    else if (h_edge && (v_count_q != CNT_MAX))
      v_count_d = v_count_q + 10'd1;
  end

  assign win_now  = in_window(h_count_q, v_count_q);
  assign win_next = in_window(h_count_d, v_count_d);

  // locked only changes when a counter is 0 or 1023, both outside the window,
  // so gating with locked_q here equals gating with next-cycle locked.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
      orgb_q    <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      orgb_q    <= (win_next && locked_q) ? rgb_s2_q : '0;
    end
  end

  assign line_len   = h_count_q + 10'd1;
  assign frame_len  = v_count_q + 10'd1;
  assign line_meas  = h_edge && (h_count_q != CNT_MAX);
  assign line_ok    = !line_meas || !ref_valid_q || (line_len == ref_line_q);
  assign frame_good = frame_ok_q && line_ok && !first_frame_q && (frame_len == v_total_q);
  assign stable_inc = stable_cnt_q + 4'd1;
  assign timeout    = (h_count_d == CNT_MAX) || (v_count_d == CNT_MAX);
  assign lock_err   = (line_meas && (line_len != h_total_q)) ||
                      (v_edge && (frame_len != v_total_q));

  // A line ending on a v edge belongs to the frame being closed, so it is
  // length-checked before the frame verdict.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= SEARCH;
      stable_cnt_q  <= '0;
      frame_ok_q    <= 1'b0;
      first_frame_q <= 1'b0;
      ref_valid_q   <= 1'b0;
      ref_line_q    <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      locked_q      <= 1'b0;
      terr_q        <= 1'b0;
      fstart_q      <= 1'b0;
    end else begin
      terr_q   <= 1'b0;
      fstart_q <= v_edge;
      if (line_meas) h_total_q <= line_len;
      if (v_edge)    v_total_q <= frame_len;
      unique case (state_q)
        SEARCH: begin
          locked_q <= 1'b0;
          if (v_edge) begin
            state_q       <= MEASURE;
            stable_cnt_q  <= '0;
            frame_ok_q    <= 1'b1;
            first_frame_q <= 1'b1;
            ref_valid_q   <= 1'b0;
          end
        end
        MEASURE: begin
          if (timeout) begin
            terr_q  <= 1'b1;
            state_q <= SEARCH;
          end else if (v_edge) begin
            frame_ok_q    <= 1'b1;
            first_frame_q <= 1'b0;
            ref_valid_q   <= 1'b0;
            if (!frame_good) begin
              stable_cnt_q <= '0;
            end else begin
              stable_cnt_q <= stable_inc;
              if (stable_inc >= LOCK_CNT) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end else if (line_meas) begin
            if (!ref_valid_q) begin
              ref_line_q  <= line_len;
              ref_valid_q <= 1'b1;
            end else if (line_len != ref_line_q) begin
              frame_ok_q <= 1'b0;
            end
          end
        end
        LOCKED: begin
          if (timeout) begin
            terr_q   <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= SEARCH;
          end else if (lock_err) begin
            terr_q        <= 1'b1;
            locked_q      <= 1'b0;
            state_q       <= MEASURE;
            stable_cnt_q  <= '0;
            frame_ok_q    <= v_edge;
            first_frame_q <= 1'b0;
            ref_valid_q   <= 1'b0;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign column       = win_now ? (h_count_q - H_LO) : '0;
  assign row          = win_now ? 9'(v_count_q - V_LO) : '0;
  assign pixel_valid  = win_now & locked_q;
  assign oRGB         = orgb_q;
  assign locked       = locked_q;
  assign frame_start  = fstart_q;
  assign h_total      = h_total_q;
  assign v_total      = v_total_q;
  assign timing_error = terr_q;

endmodule
